hazard_unit: RTL and testbench
==============================

# hazard_unit

Central hazard controller for the five-stage MIPS pipeline. It compares D-stage source registers and their use-times against the result-stage tags (`Res_E`/`Res_M`/`Res_W`) carried down the pipeline registers, and drives stalls, pipeline-register clears (including `EXMEM_clr`) and forwarding selects. It also tracks multiply/divide unit occupancy with an internal countdown and keeps a stall-cycle performance counter.

## Interface
- `MULT_CYCLES`, default 5: busy cycles loaded for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles loaded for div/divu.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `rsD`, `rtD` in 5 each: D-stage source register numbers.
- `tuseRsD`, `tuseRtD` in 2 each: use-time code for rs and rt (0 = D, 1 = E, 2 = M, 3 = unused).
- `rsE`, `rtE`, `rtM` in 5 each: source registers in E and M.
- `writeRegE`, `writeRegM`, `writeRegW` in 5 each: destination registers.
- `Res_E`, `Res_M`, `Res_W` in 2 each: result tag (NW=00, ALU=01, DM=10, PC=11).
- `mdStartE` in 1: a mult/div is in E this cycle.
- `mdIsDivE` in 1: that operation is a divide.
- `mdUseD` in 1: the D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- `excReq` in 1: exception or interrupt is taken in M.
- `eretM` in 1: eret is in M.
- `stallF`, `stallD` out 1: hold PC and IF/ID.
- `IFID_clr`, `IDEX_clr`, `EXMEM_clr` out 1: synchronous clears for the pipeline registers.
- `fwdRsD`, `fwdRtD` out 2: D-stage compare mux select (0 = RF, 1 = M, 2 = E PC+8, 3 = W).
- `fwdRsE`, `fwdRtE` out 2: ALU operand mux select (0 = ID/EX value, 1 = M, 2 = W).
- `fwdRtM` out 1: store data from W.
- `mdBusy` out 1: MDU occupied.
- `stallCount` out 32: count of cycles with `stallD`=1.

## Operation
- **Tnew by tag and stage.**
  - E: ALU=1, DM=2, PC=0.
  - M: ALU=0, DM=1, PC=0.
  - W: all 0.
  - NW never produces a hazard.
- **Data stall.** For each of rs and rt, stall when all of these hold:
  - the tuse code is not 3;
  - the register is not 0;
  - it equals a `writeReg` at stage E or M whose tag is not NW;
  - tuse < Tnew at that stage.
- **MDU stall.** `mdUseD` & `mdBusy`.
- **stall.** Data stall OR MDU stall.
- **flush.** `excReq` | `eretM`.
- **Output priority.**
  - flush: `IFID_clr`=`IDEX_clr`=`EXMEM_clr`=1, `stallF`=`stallD`=0.
  - else stall: `stallF`=`stallD`=`IDEX_clr`=1, other clears 0.
  - else all 0.
- **Forwarding** (combinational). A register-0 match never forwards.
  - **D:** priority E > M > W.
    - E is used only if `Res_E`=PC.
    - M is used if `Res_M` is ALU or PC.
    - W is used if `Res_W` is not NW.
  - **E:** M (ALU/PC) is preferred over W (not NW).
  - **M:** `fwdRtM`=1 iff `rtM`=`writeRegW`, `Res_W` is not NW, and `rtM` is not 0.
- **MDU counter** (6 bits):
  - if `mdStartE` & !flush: load `DIV_CYCLES` when `mdIsDivE`, else `MULT_CYCLES`;
  - otherwise decrement while nonzero.
  - `mdBusy` = (counter ≠ 0) | (`mdStartE` & !flush).
  - A flush does not clear a running count, because the issuing instruction has already passed M.
- **stallCount.** Increments when `stallD`=1 and wraps modulo 2^32.

## Timing
- All hazard, clear and forward outputs are combinational from the current-cycle inputs, with zero latency.
- Registered state: MDU counter and `stallCount`, both reset to 0.
  - During reset, `mdBusy`=0 provided `mdStartE`=0.
  - With all inputs idle, all outputs are 0.
- A mult in E at cycle t loads 5; `mdBusy` is high for cycles t..t+5 and low at t+6.
- A new `mdStartE` while the counter is nonzero reloads the counter.
- `excReq` in the same cycle as a stall: flush wins, and `stallCount` does not increment.
- `excReq` in the same cycle as `mdStartE`: the counter is not loaded.
- Reset during an active MDU count zeroes it on that edge.

## Structure
- The package `hazard_pkg` holds:
  - the Res tag constants (NW/ALU/DM/PC);
  - the tuse codes;
  - the D and E forward select constants;
  - a Tnew function of (tag, stage).
- Sub-module `mdu_busy_tracker` holds the counter and `mdBusy` logic, with the two latency parameters passed down.
- The top level holds the comparators, priority logic, forward muxes and `stallCount`.

## Test plan
- **Load-use:** `Res_E`=DM, `writeRegE`=8, `rsD`=8, `tuseRsD`=1 → `stallF`=`stallD`=`IDEX_clr`=1. The next cycle, with `Res_M`=DM and `writeRegM`=8, there is no stall; then `fwdRsE`=2 once the load is in W.
- **Branch after ALU:** `Res_E`=ALU, `writeRegE`=3, `rtD`=3, `tuseRtD`=0 → stall. With the producer in M as ALU, there is no stall and `fwdRtD`=1. A jal in E (`Res_E`=PC, `writeRegE`=31, `rsD`=31) → `fwdRsD`=2.
- **Register-0 and NW filtering:** `writeRegE`=0 with matching rs, or `Res_E`=NW → no stall and all forward selects 0.
- **MDU:** `mdStartE`=1, `mdIsDivE`=1 at cycle 0, then `mdUseD`=1 → stall for cycles 0..10, released at cycle 11. `stallCount` increases by 11.
- **Flush priority:** a data stall active with `excReq`=1 → all three clears 1, `stallF`=`stallD`=0, `stallCount` unchanged. The same holds with `eretM`=1.
- **Reset mid-count:** a divide in progress with `reset`=1 for one cycle → the counter is 0, `mdBusy`=0, and `stallCount` is 0 the cycle after.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds result-tag encodings, use-time codes, forward select encodings and the
// Tnew lookup (cycles until a producer's value exists, by tag and pipe stage).
package hazard_pkg;

  // Result tags carried down the pipeline with each instruction.
  localparam logic [1:0] ResNw  = 2'b00;
  localparam logic [1:0] ResAlu = 2'b01;
  localparam logic [1:0] ResDm  = 2'b10;
  localparam logic [1:0] ResPc  = 2'b11;

  // Use-time codes for D-stage source operands.
  localparam logic [1:0] TuseD    = 2'd0;
  localparam logic [1:0] TuseE    = 2'd1;
  localparam logic [1:0] TuseM    = 2'd2;
  localparam logic [1:0] TuseNone = 2'd3;

  // D-stage compare mux selects.
  localparam logic [1:0] FwdDRf  = 2'd0;
  localparam logic [1:0] FwdDM   = 2'd1;
  localparam logic [1:0] FwdDEPc = 2'd2;
  localparam logic [1:0] FwdDW   = 2'd3;

  // E-stage ALU operand mux selects.
  localparam logic [1:0] FwdERf = 2'd0;
  localparam logic [1:0] FwdEM  = 2'd1;
  localparam logic [1:0] FwdEW  = 2'd2;

  typedef enum logic [1:0] {StageE, StageM, StageW} stage_e;

  // Cycles until the producer's result is available, given where it sits now.
  function automatic logic [1:0] tnew(input logic [1:0] tag, input stage_e stage);
    logic [1:0] t;
    t = 2'd0;
    case (stage)
      StageE: begin
        if (tag == ResAlu) t = 2'd1;
        else if (tag == ResDm) t = 2'd2;
      end
      StageM: begin
        if (tag == ResDm) t = 2'd1;
      end
      default: t = 2'd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mdu_busy_tracker.sv
// Multiply/divide unit occupancy tracker.
// Loads a latency countdown when a mult/div issues in E (unless flushed) and
// reports busy while the count is nonzero or an issue is happening now.
// Ports: clk, reset (sync, active-high), md_start_i, md_is_div_i, flush_i,
//        md_busy_o.
module mdu_busy_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_i,
  input  logic md_is_div_i,
  input  logic flush_i,
  output logic md_busy_o
);

  localparam logic [5:0] MultCnt = 6'(MULT_CYCLES);
  localparam logic [5:0] DivCnt  = 6'(DIV_CYCLES);

  logic [5:0] cnt_q, cnt_d;
  logic       load;

  assign load = md_start_i & ~flush_i;

  // A flush leaves a running count alone: its issuer has already left M.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = md_is_div_i ? DivCnt : MultCnt;
    end else if (cnt_q != 6'd0) begin
      cnt_d = cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 6'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign md_busy_o = (cnt_q != 6'd0) | load;

endmodule

// File: rtl/hazard_unit.sv
// Central hazard controller for the five-stage MIPS pipeline.
// Compares D-stage sources against E/M/W destinations using result tags and
// use-times to produce stalls, pipeline-register clears and forward selects.
// Tracks MDU occupancy and counts stalled cycles.
// Ports: clk, reset (sync, active-high); D/E/M source and destination register
//        numbers, tuse codes, Res_E/M/W tags, MDU and exception controls in;
//        stallF/stallD, IFID/IDEX/EXMEM clears, fwdRsD/fwdRtD/fwdRsE/fwdRtE/
//        fwdRtM selects, mdBusy and the 32-bit stallCount out.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [1:0]  tuseRsD,
  input  logic [1:0]  tuseRtD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  rtM,
  input  logic [4:0]  writeRegE,
  input  logic [4:0]  writeRegM,
  input  logic [4:0]  writeRegW,
  input  logic [1:0]  Res_E,
  input  logic [1:0]  Res_M,
  input  logic [1:0]  Res_W,
  input  logic        mdStartE,
  input  logic        mdIsDivE,
  input  logic        mdUseD,
  input  logic        excReq,
  input  logic        eretM,
  output logic        stallF,
  output logic        stallD,
  output logic        IFID_clr,
  output logic        IDEX_clr,
  output logic        EXMEM_clr,
  output logic [1:0]  fwdRsD,
  output logic [1:0]  fwdRtD,
  output logic [1:0]  fwdRsE,
  output logic [1:0]  fwdRtE,
  output logic        fwdRtM,
  output logic        mdBusy,
  output logic [31:0] stallCount
);

  // Stall when the consumer needs the value sooner than an E/M producer has it.
  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] wr_e, input logic [1:0] res_e,
                                      input logic [4:0] wr_m, input logic [1:0] res_m);
    logic hit_e, hit_m;
    hit_e = (src == wr_e) && (res_e != ResNw) && (tuse < tnew(res_e, StageE));
    hit_m = (src == wr_m) && (res_m != ResNw) && (tuse < tnew(res_m, StageM));
    return (tuse != TuseNone) && (src != 5'd0) && (hit_e || hit_m);
  endfunction

  // Only a link (PC+8) value is ready in E; ALU/link values are ready in M.
  function automatic logic [1:0] fwd_sel_d(input logic [4:0] src,
                                           input logic [4:0] wr_e, input logic [1:0] res_e,
                                           input logic [4:0] wr_m, input logic [1:0] res_m,
                                           input logic [4:0] wr_w, input logic [1:0] res_w);
    logic [1:0] sel;
    sel = FwdDRf;
    if (src != 5'd0) begin
      if ((src == wr_e) && (res_e == ResPc)) begin
        sel = FwdDEPc;
      end else if ((src == wr_m) && ((res_m == ResAlu) || (res_m == ResPc))) begin
        sel = FwdDM;
      end else if ((src == wr_w) && (res_w != ResNw)) begin
        sel = FwdDW;
      end
    end
    return sel;
  endfunction

  function automatic logic [1:0] fwd_sel_e(input logic [4:0] src,
                                           input logic [4:0] wr_m, input logic [1:0] res_m,
                                           input logic [4:0] wr_w, input logic [1:0] res_w);
    logic [1:0] sel;
    sel = FwdERf;
    if (src != 5'd0) begin
      if ((src == wr_m) && ((res_m == ResAlu) || (res_m == ResPc))) begin
        sel = FwdEM;
      end else if ((src == wr_w) && (res_w != ResNw)) begin
        sel = FwdEW;
      end
    end
    return sel;
  endfunction

  logic        flush;
  logic        data_stall;
  logic        md_stall;
  logic        stall;
  logic        md_busy;
  logic [31:0] stall_count_q, stall_count_d;

  assign flush = excReq | eretM;

  mdu_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu_busy_tracker (
    .clk         (clk),
    .reset       (reset),
    .md_start_i  (mdStartE),
    .md_is_div_i (mdIsDivE),
    .flush_i     (flush),
    .md_busy_o   (md_busy)
  );

  assign data_stall = src_hazard(rsD, tuseRsD, writeRegE, Res_E, writeRegM, Res_M) |
                      src_hazard(rtD, tuseRtD, writeRegE, Res_E, writeRegM, Res_M);
  assign md_stall   = mdUseD & md_busy;
  assign stall      = data_stall | md_stall;

  // Flush outranks stall: the stalled instruction is being discarded anyway.
  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    IFID_clr  = 1'b0;
    IDEX_clr  = 1'b0;
    EXMEM_clr = 1'b0;
    if (flush) begin
      IFID_clr  = 1'b1;
      IDEX_clr  = 1'b1;
      EXMEM_clr = 1'b1;
    end else if (stall) begin
      stallF   = 1'b1;
      stallD   = 1'b1;
      IDEX_clr = 1'b1;
    end
  end

  assign fwdRsD = fwd_sel_d(rsD, writeRegE, Res_E, writeRegM, Res_M, writeRegW, Res_W);
  assign fwdRtD = fwd_sel_d(rtD, writeRegE, Res_E, writeRegM, Res_M, writeRegW, Res_W);
  assign fwdRsE = fwd_sel_e(rsE, writeRegM, Res_M, writeRegW, Res_W);
  assign fwdRtE = fwd_sel_e(rtE, writeRegM, Res_M, writeRegW, Res_W);
  assign fwdRtM = (rtM != 5'd0) && (rtM == writeRegW) && (Res_W != ResNw);

  assign mdBusy = md_busy;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stallD) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and randomized checks of hazard_unit against a rule-level model.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rsD, rtD, rsE, rtE, rtM, writeRegE, writeRegM, writeRegW;
  logic [1:0]  tuseRsD, tuseRtD, Res_E, Res_M, Res_W;
  logic        mdStartE, mdIsDivE, mdUseD, excReq, eretM;
  logic        stallF, stallD, IFID_clr, IDEX_clr, EXMEM_clr;
  logic [1:0]  fwdRsD, fwdRtD, fwdRsE, fwdRtE;
  logic        fwdRtM, mdBusy;
  logic [31:0] stallCount;

  int checks = 0;
  int errors = 0;

  // Model state: absolute cycle index, last cycle the MDU is busy, stall count.
  longint      cycle = 0;
  longint      busy_until = -1;
  logic [31:0] m_count = 32'd0;

  // Tnew indexed by tag (NW, ALU, DM, PC).
  int tnew_e[4] = '{0, 1, 2, 0};
  int tnew_m[4] = '{0, 0, 1, 0};

  always #5 clk = ~clk;

  hazard_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rsD        (rsD),
    .rtD        (rtD),
    .tuseRsD    (tuseRsD),
    .tuseRtD    (tuseRtD),
    .rsE        (rsE),
    .rtE        (rtE),
    .rtM        (rtM),
    .writeRegE  (writeRegE),
    .writeRegM  (writeRegM),
    .writeRegW  (writeRegW),
    .Res_E      (Res_E),
    .Res_M      (Res_M),
    .Res_W      (Res_W),
    .mdStartE   (mdStartE),
    .mdIsDivE   (mdIsDivE),
    .mdUseD     (mdUseD),
    .excReq     (excReq),
    .eretM      (eretM),
    .stallF     (stallF),
    .stallD     (stallD),
    .IFID_clr   (IFID_clr),
    .IDEX_clr   (IDEX_clr),
    .EXMEM_clr  (EXMEM_clr),
    .fwdRsD     (fwdRsD),
    .fwdRtD     (fwdRtD),
    .fwdRsE     (fwdRsE),
    .fwdRtE     (fwdRtE),
    .fwdRtM     (fwdRtM),
    .mdBusy     (mdBusy),
    .stallCount (stallCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_src_stall(input logic [4:0] r, input logic [1:0] tuse);
    if (tuse == 2'd3 || r == 5'd0) return 1'b0;
    if (r == writeRegE && Res_E != 2'd0 && int'(tuse) < tnew_e[Res_E]) return 1'b1;
    if (r == writeRegM && Res_M != 2'd0 && int'(tuse) < tnew_m[Res_M]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_fwd_d(input logic [4:0] r);
    if (r == 5'd0) return 2'd0;
    if (r == writeRegE && Res_E == 2'd3) return 2'd2;
    if (r == writeRegM && (Res_M == 2'd1 || Res_M == 2'd3)) return 2'd1;
    if (r == writeRegW && Res_W != 2'd0) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [1:0] m_fwd_e(input logic [4:0] r);
    if (r == 5'd0) return 2'd0;
    if (r == writeRegM && (Res_M == 2'd1 || Res_M == 2'd3)) return 2'd1;
    if (r == writeRegW && Res_W != 2'd0) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit m_flush();
    return excReq || eretM;
  endfunction

  function automatic bit m_busy();
    return (mdStartE && !m_flush()) || (cycle <= busy_until);
  endfunction

  function automatic bit m_stall();
    return m_src_stall(rsD, tuseRsD) || m_src_stall(rtD, tuseRtD) || (mdUseD && m_busy());
  endfunction

  task automatic check_all(input string tag);
    bit fl, st;
    fl = m_flush();
    st = m_stall() && !fl;
    check({tag, ".stallF"}, 32'(stallF), 32'(st));
    check({tag, ".stallD"}, 32'(stallD), 32'(st));
    check({tag, ".IFID_clr"}, 32'(IFID_clr), 32'(fl));
    check({tag, ".IDEX_clr"}, 32'(IDEX_clr), 32'(fl || st));
    check({tag, ".EXMEM_clr"}, 32'(EXMEM_clr), 32'(fl));
    check({tag, ".fwdRsD"}, 32'(fwdRsD), 32'(m_fwd_d(rsD)));
    check({tag, ".fwdRtD"}, 32'(fwdRtD), 32'(m_fwd_d(rtD)));
    check({tag, ".fwdRsE"}, 32'(fwdRsE), 32'(m_fwd_e(rsE)));
    check({tag, ".fwdRtE"}, 32'(fwdRtE), 32'(m_fwd_e(rtE)));
    check({tag, ".fwdRtM"}, 32'(fwdRtM),
          32'(rtM != 5'd0 && rtM == writeRegW && Res_W != 2'd0));
    check({tag, ".mdBusy"}, 32'(mdBusy), 32'(m_busy()));
    check({tag, ".stallCount"}, stallCount, m_count);
  endtask

  // Advance the model across the coming clock edge using the current inputs.
  task automatic model_tick();
    bit st;
    st = m_stall() && !m_flush();
    if (reset) begin
      busy_until = -1;
      m_count    = 32'd0;
    end else begin
      if (mdStartE && !m_flush()) busy_until = cycle + (mdIsDivE ? 10 : 5);
      if (st) m_count = m_count + 32'd1;
    end
    cycle++;
  endtask

  // Inputs are applied at the falling edge; outputs are sampled 1 time unit later.
  task automatic step(input string tag);
    #1;
    check_all(tag);
    model_tick();
    @(negedge clk);
  endtask

  task automatic idle();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; rtM = 0;
    writeRegE = 0; writeRegM = 0; writeRegW = 0;
    tuseRsD = 2'd3; tuseRtD = 2'd3;
    Res_E = 0; Res_M = 0; Res_W = 0;
    mdStartE = 0; mdIsDivE = 0; mdUseD = 0; excReq = 0; eretM = 0;
  endtask

  function automatic logic [4:0] rand_reg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] sc;
    idle();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    step("reset");
    reset = 1'b0;
    step("idle");

    // Load-use: load in E, consumer needs rs in E.
    Res_E = 2'd2; writeRegE = 8; rsD = 8; tuseRsD = 2'd1;
    #1;
    check("lu_stallF", 32'(stallF), 32'd1);
    check("lu_stallD", 32'(stallD), 32'd1);
    check("lu_idex", 32'(IDEX_clr), 32'd1);
    step("lu0");
    Res_E = 0; writeRegE = 0; Res_M = 2'd2; writeRegM = 8;
    #1;
    check("lu_m_nostall", 32'(stallD), 32'd0);
    step("lu1");
    Res_M = 0; writeRegM = 0; Res_W = 2'd2; writeRegW = 8; rsE = 8;
    #1;
    check("lu_fwdRsE", 32'(fwdRsE), 32'd2);
    step("lu2");

    // Branch after ALU.
    idle();
    Res_E = 2'd1; writeRegE = 3; rtD = 3; tuseRtD = 2'd0;
    #1;
    check("br_stall", 32'(stallD), 32'd1);
    step("br0");
    Res_E = 0; writeRegE = 0; Res_M = 2'd1; writeRegM = 3;
    #1;
    check("br_nostall", 32'(stallD), 32'd0);
    check("br_fwdRtD", 32'(fwdRtD), 32'd1);
    step("br1");
    idle();
    Res_E = 2'd3; writeRegE = 31; rsD = 31; tuseRsD = 2'd0;
    #1;
    check("jal_fwdRsD", 32'(fwdRsD), 32'd2);
    step("jal");

    // Register 0 and NW filtering.
    idle();
    Res_E = 2'd1; writeRegE = 0; rsD = 0; tuseRsD = 2'd0;
    #1;
    check("r0_stall", 32'(stallD), 32'd0);
    check("r0_fwd", 32'(fwdRsD), 32'd0);
    step("r0");
    Res_E = 2'd0; writeRegE = 5; rsD = 5;
    #1;
    check("nw_stall", 32'(stallD), 32'd0);
    check("nw_fwd", 32'(fwdRsD), 32'd0);
    step("nw");

    // Divide occupancy stalls an MDU consumer for 11 cycles.
    idle();
    sc = m_count;
    mdStartE = 1; mdIsDivE = 1; mdUseD = 1;
    for (int i = 0; i < 11; i++) begin
      #1;
      check("div_stall", 32'(stallD), 32'd1);
      step("div");
      mdStartE = 0; mdIsDivE = 0;
    end
    #1;
    check("div_release", 32'(stallD), 32'd0);
    check("div_count", stallCount - sc, 32'd11);
    step("div_end");

    // Flush priority over a data stall (excReq, then eretM).
    for (int k = 0; k < 2; k++) begin
      idle();
      Res_E = 2'd2; writeRegE = 9; rsD = 9; tuseRsD = 2'd0;
      excReq = (k == 0); eretM = (k == 1);
      sc = m_count;
      #1;
      check("fl_ifid", 32'(IFID_clr), 32'd1);
      check("fl_exmem", 32'(EXMEM_clr), 32'd1);
      check("fl_stallF", 32'(stallF), 32'd0);
      step("flush");
      idle();
      #1;
      check("fl_count", stallCount, sc);
      step("flush_after");
    end

    // Flush in the same cycle as an MDU issue suppresses the load.
    idle();
    mdStartE = 1; excReq = 1;
    step("md_flush");
    idle();
    #1;
    check("md_flush_busy", 32'(mdBusy), 32'd0);
    step("md_flush_after");

    // Reset in the middle of a divide.
    idle();
    mdStartE = 1; mdIsDivE = 1;
    step("rst_div0");
    mdStartE = 0; mdIsDivE = 0; mdUseD = 1;
    step("rst_div1");
    reset = 1'b1; mdUseD = 0;
    step("rst_div2");
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(mdBusy), 32'd0);
    check("rst_count", stallCount, 32'd0);
    step("rst_div3");

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rsD = rand_reg(); rtD = rand_reg(); rsE = rand_reg(); rtE = rand_reg();
      rtM = rand_reg();
      writeRegE = rand_reg(); writeRegM = rand_reg(); writeRegW = rand_reg();
      tuseRsD = 2'($urandom); tuseRtD = 2'($urandom);
      Res_E = 2'($urandom); Res_M = 2'($urandom); Res_W = 2'($urandom);
      mdStartE = ($urandom_range(0, 7) == 0);
      mdIsDivE = 1'($urandom);
      mdUseD   = 1'($urandom);
      excReq   = ($urandom_range(0, 19) == 0);
      eretM    = ($urandom_range(0, 29) == 0);
      reset    = ($urandom_range(0, 149) == 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
